// File: rtl/int_sqrt_seq.sv
// Sequential integer square root, restoring digit-by-digit method.
// Each CALC cycle consumes the next two operand bits and produces one root bit.
// After RW steps the root and remainder are published on sqrt/rem with a
// one-cycle done pulse; both outputs then hold until the next completion.
module int_sqrt_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 S,
    input  logic [WIDTH-1:0]     X,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   sqrt,
    output logic [WIDTH/2:0]     rem
);
    localparam int RW = WIDTH / 2;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [RW-1:0]   root_q, root_d;
    logic [RW+1:0]   prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   sqrt_q, sqrt_d;
    logic [RW:0]     rem_q, rem_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [1:0]      pair_s;
    logic            take_s;
    logic [RW+1:0]   prem_step_s;
    logic [RW-1:0]   root_step_s;

    // Next-state, one root-bit step, and registered handshake outputs.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        root_d  = root_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        sqrt_d  = sqrt_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        pair_s = op_q[WIDTH-1 -: 2];
        // The trial is non-negative exactly when the full-width shifted
        // remainder is at least {root,01}; the difference itself always
        // fits the RW+2-bit partial remainder.
        take_s = ({prem_q, pair_s} >= {2'b00, root_q, 2'b01});
        if (take_s) begin
            prem_step_s = {prem_q[RW-1:0], pair_s} - {root_q, 2'b01};
            root_step_s = {root_q[RW-2:0], 1'b1};
        end else begin
            prem_step_s = {prem_q[RW-1:0], pair_s};
            root_step_s = {root_q[RW-2:0], 1'b0};
        end

        case (state_q)
            IDLE: begin
                if (S) begin
                    state_d = CALC;
                    op_d    = X;
                    root_d  = {RW{1'b0}};
                    prem_d  = {(RW+2){1'b0}};
                    cnt_d   = CW'(RW - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                prem_d = prem_step_s;
                root_d = root_step_s;
                op_d   = {op_q[WIDTH-3:0], 2'b00};
                if (cnt_q == {CW{1'b0}}) begin
                    cnt_d   = {CW{1'b0}};
                    sqrt_d  = root_step_s;
                    rem_d   = prem_step_s[RW:0];
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CALC);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            op_q    <= {WIDTH{1'b0}};
            root_q  <= {RW{1'b0}};
            prem_q  <= {(RW+2){1'b0}};
            cnt_q   <= {CW{1'b0}};
            sqrt_q  <= {RW{1'b0}};
            rem_q   <= {(RW+1){1'b0}};
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            root_q  <= root_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            sqrt_q  <= sqrt_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sqrt  = sqrt_q;
    assign rem   = rem_q;
endmodule

// File: tb/tb_int_sqrt_seq.sv
// Scoreboard bench for int_sqrt_seq at WIDTH = 8, 16 and 32.
// Drivers push expected operands and completion cycles; per-width monitors
// pop on done and compare against a real-arithmetic square-root model.
module tb_int_sqrt_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        longint x;
        int     ecyc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t q32[$];

    // DUT signals
    logic        rst8, s8, rdy8, bsy8, dn8;
    logic [7:0]  x8;
    logic [3:0]  sq8;
    logic [4:0]  rm8;
    logic        rst16, s16, rdy16, bsy16, dn16;
    logic [15:0] x16;
    logic [7:0]  sq16;
    logic [8:0]  rm16;
    logic        rst32, s32, rdy32, bsy32, dn32;
    logic [31:0] x32;
    logic [15:0] sq32;
    logic [16:0] rm32;

    int_sqrt_seq #(.WIDTH(8)) u8 (
        .CLK(clk), .RESET(rst8), .S(s8), .X(x8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .sqrt(sq8), .rem(rm8));
    int_sqrt_seq #(.WIDTH(16)) u16 (
        .CLK(clk), .RESET(rst16), .S(s16), .X(x16),
        .ready(rdy16), .busy(bsy16), .done(dn16), .sqrt(sq16), .rem(rm16));
    int_sqrt_seq #(.WIDTH(32)) u32 (
        .CLK(clk), .RESET(rst32), .S(s32), .X(x32),
        .ready(rdy32), .busy(bsy32), .done(dn32), .sqrt(sq32), .rem(rm32));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: largest r with r*r <= x, from real sqrt then integer fix-up.
    function automatic longint ref_root(input longint x);
        longint r;
        r = longint'($floor($sqrt(real'(x))));
        while (r > 0 && r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic score(input string tag, input exp_t e, input longint sq,
                         input longint rm, input logic rdy, input logic bsy);
        longint r;
        r = ref_root(e.x);
        chk({tag, " sqrt"}, sq, r);
        chk({tag, " rem"}, rm, e.x - r * r);
        chk({tag, " done latency"}, longint'(cyc), longint'(e.ecyc));
        chk({tag, " ready/busy at done"}, longint'({rdy, bsy}), 0);
        chk({tag, " bound"}, longint'((sq * sq <= e.x) && (e.x < (sq + 1) * (sq + 1))), 1);
    endtask

    // Monitors
    logic pd8 = 1'b0, pd16 = 1'b0, pd32 = 1'b0;

    always @(negedge clk) begin
        if (dn8 === 1'b1) begin
            if (q8.size() == 0) chk("w8 unexpected done", 1, 0);
            else begin
                score("w8", q8[0], sq8, rm8, rdy8, bsy8);
                q8.delete(0);
            end
        end
        if (pd8) chk("w8 ready after done", longint'(rdy8), 1);
        pd8 <= (dn8 === 1'b1);
    end

    always @(negedge clk) begin
        if (dn16 === 1'b1) begin
            if (q16.size() == 0) chk("w16 unexpected done", 1, 0);
            else begin
                score("w16", q16[0], sq16, rm16, rdy16, bsy16);
                q16.delete(0);
            end
        end
        if (pd16) chk("w16 ready after done", longint'(rdy16), 1);
        pd16 <= (dn16 === 1'b1);
    end

    always @(negedge clk) begin
        if (dn32 === 1'b1) begin
            if (q32.size() == 0) chk("w32 unexpected done", 1, 0);
            else begin
                score("w32", q32[0], sq32, rm32, rdy32, bsy32);
                q32.delete(0);
            end
        end
        if (pd32) chk("w32 ready after done", longint'(rdy32), 1);
        pd32 <= (dn32 === 1'b1);
    end

    // Drivers: wait for ready at a falling edge, present S/X, record expectation.
    task automatic issue8(input longint x);
        int n = 0;
        @(negedge clk);
        while (rdy8 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (rdy8 !== 1'b1) begin chk("w8 ready timeout", 0, 1); return; end
        x8 = x[7:0]; s8 = 1'b1;
        q8.push_back('{x, cyc + 1 + 4});
        @(negedge clk); s8 = 1'b0;
    endtask

    task automatic issue16(input longint x, input bit hold, output int icyc);
        int n = 0;
        icyc = cyc;
        @(negedge clk);
        while (rdy16 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (rdy16 !== 1'b1) begin chk("w16 ready timeout", 0, 1); return; end
        x16 = x[15:0]; s16 = 1'b1; icyc = cyc;
        q16.push_back('{x, cyc + 1 + 8});
        if (!hold) begin @(negedge clk); s16 = 1'b0; end
    endtask

    task automatic issue32(input longint x);
        int n = 0;
        @(negedge clk);
        while (rdy32 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (rdy32 !== 1'b1) begin chk("w32 ready timeout", 0, 1); return; end
        x32 = x[31:0]; s32 = 1'b1;
        q32.push_back('{x, cyc + 1 + 16});
        @(negedge clk); s32 = 1'b0;
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("w16 drain", longint'(q16.size()), 0);
    endtask

    initial begin
        int c;
        int n;
        rst8 = 1'b1; rst16 = 1'b1; rst32 = 1'b1;
        s8 = 1'b0; s16 = 1'b0; s32 = 1'b0;
        x8 = 8'd0; x16 = 16'd0; x32 = 32'd0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0; rst32 = 1'b0;
        chk("w16 reset ready", longint'(rdy16), 1);
        chk("w16 reset busy", longint'(bsy16), 0);
        chk("w16 reset done", longint'(dn16), 0);
        chk("w16 reset sqrt", longint'(sq16), 0);
        chk("w16 reset rem", longint'(rm16), 0);
        chk("w8 reset ready", longint'(rdy8), 1);
        chk("w32 reset ready", longint'(rdy32), 1);

        fork
            begin : drv16
                issue16(64'd0, 1'b0, c);
                chk("w16 busy in calc", longint'({rdy16, bsy16}), 1);
                issue16(64'd65535, 1'b0, c);
                issue16(64'd144, 1'b0, c);
                issue16(64'd200, 1'b0, c);
                // S held high across CALC with X changed: second op auto-starts
                issue16(64'd200, 1'b1, c);
                @(negedge clk);
                x16 = 16'd9;
                chk("w16 busy while S held", longint'(bsy16), 1);
                issue16(64'd9, 1'b0, c);
                chk("w16 sqrt held during op", longint'(sq16), 14);
                chk("w16 rem held during op", longint'(rm16), 4);
                drain16();
                repeat (3) @(negedge clk);
                chk("w16 sqrt held idle", longint'(sq16), 3);
                chk("w16 rem held idle", longint'(rm16), 0);
                // Reset during the 4th CALC cycle aborts the operation
                issue16(64'd1000, 1'b0, c);
                n = 0;
                while (cyc < c + 4 && n < 50) begin @(negedge clk); n++; end
                chk("w16 busy before abort", longint'(bsy16), 1);
                rst16 = 1'b1;
                if (q16.size() != 0) q16.delete(q16.size() - 1);
                @(negedge clk);
                rst16 = 1'b0;
                chk("w16 abort ready", longint'(rdy16), 1);
                chk("w16 abort busy", longint'(bsy16), 0);
                chk("w16 abort done", longint'(dn16), 0);
                chk("w16 abort sqrt", longint'(sq16), 0);
                chk("w16 abort rem", longint'(rm16), 0);
                issue16(64'd1000, 1'b0, c);
                for (int i = 0; i < 40; i++)
                    issue16(longint'($urandom_range(0, 65535)), 1'b0, c);
            end
            begin : drv8
                for (int v = 0; v < 256; v++) issue8(longint'(v));
            end
            begin : drv32
                issue32(64'd4294967295);
                issue32(64'd1);
                for (int i = 0; i < 20; i++) issue32(longint'($urandom));
            end
        join

        n = 0;
        while ((q8.size() + q16.size() + q32.size()) != 0 && n < 200) begin
            @(negedge clk); n++;
        end
        chk("all queues drained", longint'(q8.size() + q16.size() + q32.size()), 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/int_sqrt_seq.md
Name: int_sqrt_seq

Overview:
- Parametrised sequential integer square-root unit; successor to the fixed 8-bit ASM-chart square-root calculator.
- Computes floor(sqrt(X)) and remainder X - sqrt^2 for a WIDTH-bit unsigned operand.
- Uses the digit-by-digit (two bits per step) method, one result bit per clock.
- Adds a ready/done handshake and registered, held results for use by datapath controllers.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4. Root width is RW = WIDTH/2.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- S  input  1  start request; sampled only when ready=1.
- X  input  WIDTH  unsigned operand; captured on the accepting edge.
- ready  output  1  high when idle and able to accept S.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: sqrt/rem have just been updated.
- sqrt  output  RW  floor(sqrt(X)) of the last completed operation.
- rem  output  RW+1  X - sqrt^2 of the last completed operation; range 0..2*sqrt.

Behaviour:
- Reset: on a rising edge with RESET=1, state=IDLE, ready=1, busy=0, done=0, sqrt=0, rem=0, and all working registers cleared. RESET overrides every other input, including mid-operation; the aborted operation produces no done.
- States: IDLE, CALC, DONE.
- IDLE: ready=1, busy=0.
  - On an edge with S=1: latch X into the working operand, clear the working root and partial remainder, load the step counter with RW-1, and go to CALC.
  - With S=0: stay in IDLE.
- CALC: ready=0, busy=1. Each edge performs one step:
  - trial = {partial_rem, next two MSBs of operand} - {root, 2'b01}.
  - If trial >= 0: partial_rem = trial, root = {root, 1}.
  - Otherwise: partial_rem = {partial_rem, two bits}, root = {root, 0}.
  - Shift the operand left by 2 and decrement the counter.
  - On the edge that performs step RW (counter = 0): copy root to sqrt and the final remainder to rem, assert done, and go to DONE.
- DONE: done=1, ready=0, busy=0 for exactly one cycle, then go to IDLE. S is ignored in this state.
- Latency: done is high in the cycle after RW edges following the accepting edge (WIDTH=16: accept edge E0, done high between E8 and E9). Throughput is one result per RW+2 cycles.
- S held high continuously starts a new operation on every IDLE edge. X may change freely after the accepting edge.
- sqrt/rem change only on the completing edge or on reset, and hold between operations.
- Arithmetic: the partial remainder register is RW+2 bits wide, so the trial sign is detectable. No overflow is possible: for X = 2^WIDTH - 1, sqrt = 2^RW - 1 and rem = 2^(RW+1) - 2.

Test Plan:
- WIDTH=16, reset, then S=1 for one cycle with X=0 -> done pulses 8 cycles after accept, sqrt=0, rem=0; ready returns the cycle after done.
- WIDTH=16, X=65535 -> sqrt=255, rem=510. X=144 -> sqrt=12, rem=0. X=200 -> sqrt=14, rem=4.
- WIDTH=16, S=1 with X=200, then X changed to 9 and S kept high during CALC -> first result is 14/4 (X change and S ignored while busy); second operation auto-starts after DONE and yields 3/0; results hold between operations.
- WIDTH=16, start X=1000, assert RESET on the 4th CALC cycle -> no done pulse, sqrt=0, rem=0, ready=1 next cycle; new start with X=1000 yields 31/39.
- WIDTH=8, exhaustive sweep X=0..255 (one start per IDLE) -> every result satisfies sqrt^2 <= X < (sqrt+1)^2 and rem = X - sqrt^2; done latency is exactly 4 cycles each time.
- WIDTH=32, X=4294967295 -> sqrt=65535, rem=131070; X=1 -> sqrt=1, rem=0.
